lock_supervisor: RTL and testbench

LOCK_SUPERVISOR -- requirements
Module: lock_supervisor

---
 rtl/lock_pkg.sv | 33 +++
 rtl/lock_timer.sv | 36 +++
 rtl/lock_supervisor.sv | 192 +++++++++++++++++++
 tb/tb_lock_supervisor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding and code constants for the keypad lock supervisor
package lock_pkg;

  localparam int DIGITS = 4;
  localparam logic [3:0] MAX_KEY = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER   = 3'd1,
    S_OPEN    = 3'd2,
    S_ERROR   = 3'd3,
    S_LOCKOUT = 3'd4,
    S_PROG    = 3'd5
  } state_t;

  // Entry 0 is the first key of the code.
  localparam logic [DIGITS-1:0][3:0] DEFAULT_CODE = {4'd3, 4'd2, 4'd1, 4'd0};

  // Builds the reset code for any digit count; positions past DEFAULT_CODE continue the 0..9 ramp.
  function automatic logic [3:0] default_digit(input int idx);
    logic [3:0] d;
    d = 4'(idx % 10);
    for (int k = 0; k < DIGITS; k++) begin
      if (k == idx) d = DEFAULT_CODE[k];
    end
    return d;
  endfunction

  function automatic logic key_bad(input logic [3:0] k);
    return k > MAX_KEY;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - lockout down-counter that reloads to LOCK_CYCLES-1 and holds at zero
module lock_timer #(
  parameter int LOCK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [W-1:0] RELOAD = W'(LOCK_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/lock_supervisor.sv
// rtl/lock_supervisor.sv - keypad code lock: entry, lockout after repeated failures, reprogramming
module lock_supervisor #(
  parameter int DIGITS      = lock_pkg::DIGITS,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       prog_req,
  output logic       unlocked,
  output logic       locked_out,
  output logic [2:0] progress,
  output logic [1:0] fail_cnt,
  output logic       ok_pulse,
  output logic       err_pulse,
  output logic [2:0] state
);

  import lock_pkg::*;

  localparam logic [2:0] LAST_IDX   = 3'(DIGITS - 1);
  localparam logic [2:0] FULL       = 3'(DIGITS);
  localparam logic [1:0] FAIL_LIMIT = 2'(MAX_FAIL);

  state_t                  state_q, state_d;
  logic [2:0]              progress_q, progress_d;
  logic [1:0]              fail_q, fail_d;
  logic                    mismatch_q, mismatch_d;
  logic [DIGITS-1:0][3:0]  code_q, code_d;
  logic [DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic                    ok_q, ok_d;
  logic                    err_q, err_d;
  logic                    unlocked_q, locked_q;

  logic [2:0] key_idx;
  logic [3:0] expected_key;
  logic       key_miss;
  logic       entry_miss;
  logic [1:0] fail_inc;
  logic       timer_load;
  logic       timer_count;
  logic       timer_expired;

  lock_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .count  (timer_count),
    .expired(timer_expired)
  );

  // A wrong key only sets the sticky mismatch flag; the verdict waits for the last key.
  always_comb begin
    key_idx      = (state_q == S_IDLE) ? 3'd0 : progress_q;
    expected_key = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (key_idx == 3'(k)) expected_key = code_q[k];
    end
    key_miss   = key_bad(key_code) || (key_code != expected_key);
    entry_miss = key_miss || ((state_q == S_ENTER) && mismatch_q);
    fail_inc   = (fail_q >= FAIL_LIMIT) ? fail_q : fail_q + 2'd1;
  end

  always_comb begin
    state_d    = state_q;
    progress_d = progress_q;
    fail_d     = fail_q;
    mismatch_d = mismatch_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE, S_ENTER: begin
        if (key_valid) begin
          mismatch_d = entry_miss;
          progress_d = key_idx + 3'd1;
          if (key_idx == LAST_IDX) begin
            if (!entry_miss) begin
              state_d = S_OPEN;
              ok_d    = 1'b1;
              fail_d  = 2'd0;
            end else begin
              fail_d  = fail_inc;
              err_d   = 1'b1;
              state_d = (fail_inc == FAIL_LIMIT) ? S_LOCKOUT : S_ERROR;
            end
          end else begin
            state_d = S_ENTER;
          end
        end
      end

      S_ERROR: begin
        state_d    = S_IDLE;
        progress_d = 3'd0;
        mismatch_d = 1'b0;
      end

      S_OPEN: begin
        if (prog_req) begin
          state_d    = S_PROG;
          progress_d = 3'd0;
        end else if (key_valid) begin
          state_d    = S_IDLE;
          progress_d = 3'd0;
        end
      end

      S_PROG: begin
        if (key_valid) begin
          if (key_bad(key_code)) begin
            state_d    = S_IDLE;
            progress_d = 3'd0;
          end else begin
            for (int k = 0; k < DIGITS; k++) begin
              if (progress_q == 3'(k)) shadow_d[k] = key_code;
            end
            if (progress_q == LAST_IDX) begin
              code_d     = shadow_d;
              state_d    = S_IDLE;
              progress_d = 3'd0;
            end else begin
              progress_d = progress_q + 3'd1;
            end
          end
        end
      end

      S_LOCKOUT: begin
        if (timer_expired) begin
          state_d    = S_IDLE;
          fail_d     = 2'd0;
          progress_d = 3'd0;
          mismatch_d = 1'b0;
        end
      end

      default: begin
        state_d    = S_IDLE;
        progress_d = 3'd0;
      end
    endcase

    if (progress_d > FULL) progress_d = FULL;
  end

  assign timer_load  = (state_d == S_LOCKOUT) && (state_q != S_LOCKOUT);
  assign timer_count = (state_q == S_LOCKOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      progress_q <= 3'd0;
      fail_q     <= 2'd0;
      mismatch_q <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        code_q[i]   <= default_digit(i);
        shadow_q[i] <= 4'd0;
      end
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      fail_q     <= fail_d;
      mismatch_q <= mismatch_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      unlocked_q <= (state_d == S_OPEN);
      locked_q   <= (state_d == S_LOCKOUT);
      code_q     <= code_d;
      shadow_q   <= shadow_d;
    end
  end

  assign unlocked   = unlocked_q;
  assign locked_out = locked_q;
  assign progress   = progress_q;
  assign fail_cnt   = fail_q;
  assign ok_pulse   = ok_q;
  assign err_pulse  = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// tb/tb_lock_supervisor.sv - scoreboard bench for lock_supervisor with directed key sequences
module tb_lock_supervisor;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTER   = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_ERROR   = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;
  localparam logic [2:0] ST_PROG    = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       prog_req = 1'b0;
  logic       unlocked, locked_out, ok_pulse, err_pulse;
  logic [2:0] progress, state;
  logic [1:0] fail_cnt;

  typedef struct packed {
    logic       ok;
    logic [1:0] fail;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lock_supervisor #(
    .DIGITS(4),
    .MAX_FAIL(3),
    .LOCK_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .prog_req  (prog_req),
    .unlocked  (unlocked),
    .locked_out(locked_out),
    .progress  (progress),
    .fail_cnt  (fail_cnt),
    .ok_pulse  (ok_pulse),
    .err_pulse (err_pulse),
    .state     (state)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Verdict monitor: every ok/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && (ok_pulse || err_pulse)) begin
      chk("verdict_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ok_pulse", ok_pulse, e.ok);
        chk("err_pulse", err_pulse, !e.ok);
        chk("fail_cnt_at_verdict", fail_cnt, e.fail);
        chk("state_at_verdict", state, e.st);
        chk("unlocked_at_verdict", unlocked, e.st == ST_OPEN);
        chk("locked_out_at_verdict", locked_out, e.st == ST_LOCKOUT);
      end
    end
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic enter_code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d, input logic e_ok, input logic [1:0] e_fail,
                            input logic [2:0] e_st);
    press(a);
    press(b);
    press(c);
    exp_q.push_back(exp_t'{ok: e_ok, fail: e_fail, st: e_st});
    press(d);
  endtask

  task automatic pulse_prog();
    @(negedge clk);
    prog_req = 1'b1;
    @(negedge clk);
    prog_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;

    repeat (3) @(negedge clk);
    chk("reset_state", state, ST_IDLE);
    chk("reset_unlocked", unlocked, 0);
    chk("reset_locked_out", locked_out, 0);
    chk("reset_progress", progress, 0);
    chk("reset_fail_cnt", fail_cnt, 0);
    chk("reset_ok_pulse", ok_pulse, 0);
    chk("reset_err_pulse", err_pulse, 0);
    reset = 1'b0;
    @(negedge clk);

    // Default code opens.
    enter_code(4'd0, 4'd1, 4'd2, 4'd3, 1'b1, 2'd0, ST_OPEN);
    @(negedge clk);
    chk("ok_single_cycle", ok_pulse, 0);
    chk("open_holds", state, ST_OPEN);
    chk("open_unlocked", unlocked, 1);
    press(4'd5);
    chk("relock_state", state, ST_IDLE);
    chk("relock_key_discarded", progress, 0);

    // Wrong second key: no verdict until the fourth key.
    press(4'd0);
    chk("enter_first_state", state, ST_ENTER);
    chk("enter_first_progress", progress, 1);
    press(4'd5);
    chk("enter_second_progress", progress, 2);
    press(4'd2);
    chk("enter_third_progress", progress, 3);
    chk("no_early_err", err_pulse, 0);
    exp_q.push_back(exp_t'{ok: 1'b0, fail: 2'd1, st: ST_ERROR});
    press(4'd3);
    @(negedge clk);
    chk("error_to_idle", state, ST_IDLE);
    chk("error_progress_clear", progress, 0);
    chk("error_fail_cnt", fail_cnt, 1);

    // Key above 9 is a mismatch, then the third failure locks out.
    enter_code(4'd0, 4'd1, 4'd12, 4'd3, 1'b0, 2'd2, ST_ERROR);
    @(negedge clk);
    enter_code(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 2'd3, ST_LOCKOUT);
    lc = 0;
    while (locked_out && lc < 40) begin
      lc++;
      key_valid = lc[0];
      key_code  = 4'd0;
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk("lockout_cycles", lc, 16);
    chk("lockout_exit_state", state, ST_IDLE);
    chk("lockout_exit_fail_cnt", fail_cnt, 0);
    chk("lockout_exit_progress", progress, 0);

    // Reprogram to 7,7,1,9.
    enter_code(4'd0, 4'd1, 4'd2, 4'd3, 1'b1, 2'd0, ST_OPEN);
    pulse_prog();
    chk("prog_entry_state", state, ST_PROG);
    chk("prog_entry_progress", progress, 0);
    press(4'd7);
    press(4'd7);
    press(4'd1);
    chk("prog_progress", progress, 3);
    press(4'd9);
    chk("prog_done_state", state, ST_IDLE);
    chk("prog_done_progress", progress, 0);
    enter_code(4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 2'd1, ST_ERROR);
    @(negedge clk);
    enter_code(4'd7, 4'd7, 4'd1, 4'd9, 1'b1, 2'd0, ST_OPEN);

    // prog_req beats a simultaneous key in OPEN.
    @(negedge clk);
    prog_req  = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd5;
    @(negedge clk);
    prog_req  = 1'b0;
    key_valid = 1'b0;
    chk("prog_wins_state", state, ST_PROG);
    chk("prog_wins_progress", progress, 0);
    chk("prog_wins_unlocked", unlocked, 0);

    // Invalid key aborts programming; old code still opens.
    press(4'd4);
    chk("prog_abort_pre_progress", progress, 1);
    press(4'd12);
    chk("prog_abort_state", state, ST_IDLE);
    chk("prog_abort_progress", progress, 0);
    enter_code(4'd7, 4'd7, 4'd1, 4'd9, 1'b1, 2'd0, ST_OPEN);

    // prog_req outside OPEN is ignored.
    press(4'd0);
    pulse_prog();
    chk("prog_ignored_idle", state, ST_IDLE);

    // Reset during entry restores the default code.
    press(4'd7);
    chk("mid_entry_state", state, ST_ENTER);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'd7;
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_state", state, ST_IDLE);
    chk("mid_reset_progress", progress, 0);
    @(negedge clk);
    key_valid = 1'b0;
    reset     = 1'b0;
    enter_code(4'd0, 4'd1, 4'd2, 4'd3, 1'b1, 2'd0, ST_OPEN);

    repeat (2) @(negedge clk);
    chk("pending_verdicts", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
